// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch-operand
// stalls, taken-branch slot squash, multi-cycle MULT/DIV front-end freeze.
module hazard_stall_controller #(
  parameter int MD_LAT     = 4,
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             md_start,
  input  logic             clr_stats,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = (MD_LAT > 2) ? CW'(MD_LAT - 2) : {CW{1'b0}};
  localparam logic MD_EN    = (MD_LAT > 1);
  localparam logic MD_LONG  = (MD_LAT > 2);
  localparam logic FLUSH_EN = (DELAY_SLOT == 0);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic            lu_s;
  logic            br1_s;
  logic            md_stall_s;
  logic            data_stall_s;
  logic            ctrl_flush_s;

  // r0 never carries a dependency, so a zero destination cannot match
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  // Hazard detection terms against the EX and MEM destinations
  always_comb begin
    lu_s  = ex_mem_read && reg_match(ex_rd, id_rs, id_rt, id_uses_rt);
    br1_s = id_is_branch &&
            ((ex_reg_write && !ex_mem_read && reg_match(ex_rd, id_rs, id_rt, id_uses_rt)) ||
             (mem_mem_read && reg_match(mem_rd, id_rs, id_rt, id_uses_rt)));
  end

  // FSM state and MULT/DIV remaining-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state and priority-encoded stall/flush decision (MD > data > control)
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    md_stall_s   = 1'b0;
    data_stall_s = 1'b0;
    ctrl_flush_s = 1'b0;
    if (reset) begin
      state_s = RUN;
      cnt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (md_start && MD_EN) begin
            md_stall_s = 1'b1;
            if (MD_LONG) begin
              state_s = MD_BUSY;
              cnt_s   = CNT_INIT;
            end else begin
              state_s = RUN;
            end
          end else if (lu_s || br1_s) begin
            data_stall_s = 1'b1;
          end else if ((branch_taken || jump) && FLUSH_EN) begin
            ctrl_flush_s = 1'b1;
          end else begin
            ctrl_flush_s = 1'b0;
          end
        end
        MD_BUSY: begin
          md_stall_s = 1'b1;
          if (cnt_r == CW'(1)) begin
            state_s = RUN;
            cnt_s   = {CW{1'b0}};
          end else begin
            cnt_s = cnt_r - CW'(1);
          end
        end
        default: begin
          state_s = RUN;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Output decode; every term is already zero while reset is high
  always_comb begin
    pc_hold     = md_stall_s | data_stall_s;
    ifid_hold   = md_stall_s | data_stall_s;
    idex_hold   = md_stall_s;
    exmem_flush = md_stall_s;
    md_busy     = md_stall_s;
    idex_flush  = data_stall_s;
    ifid_flush  = ctrl_flush_s;
  end

  // Saturating stall-cycle statistics counter; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (clr_stats) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (pc_hold && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: four parameter variants share one stimulus stream and are
// checked each cycle against a behavioural model of the hazard controller.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rt, id_is_branch, ex_mem_read, ex_reg_write, mem_mem_read;
  logic       branch_taken, jump, md_start, clr_stats;

  // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_flush, md_busy}
  logic [6:0]  o0, o1, o2, o3;
  logic [3:0]  c0;
  logic [15:0] c1, c2, c3;
  logic [3:0][6:0]  act_o;
  logic [3:0][15:0] act_c;
  always_comb act_o = {o3, o2, o1, o0};
  always_comb act_c = {c3, c2, c1, {12'd0, c0}};

  // 0: MD_LAT=4 CNT_W=4, 1: DELAY_SLOT=1, 2: MD_LAT=1, 3: MD_LAT=2
  localparam int LAT[4] = '{4, 4, 1, 2};
  localparam int DS[4]  = '{0, 1, 0, 0};
  localparam int SAT[4] = '{15, 65535, 65535, 65535};

  hazard_stall_controller #(.MD_LAT(4), .DELAY_SLOT(0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .branch_taken(branch_taken),
    .jump(jump), .md_start(md_start), .clr_stats(clr_stats),
    .pc_hold(o0[6]), .ifid_hold(o0[5]), .ifid_flush(o0[4]), .idex_hold(o0[3]),
    .idex_flush(o0[2]), .exmem_flush(o0[1]), .md_busy(o0[0]), .stall_count(c0));

  hazard_stall_controller #(.MD_LAT(4), .DELAY_SLOT(1), .CNT_W(16)) dut_ds (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .branch_taken(branch_taken),
    .jump(jump), .md_start(md_start), .clr_stats(clr_stats),
    .pc_hold(o1[6]), .ifid_hold(o1[5]), .ifid_flush(o1[4]), .idex_hold(o1[3]),
    .idex_flush(o1[2]), .exmem_flush(o1[1]), .md_busy(o1[0]), .stall_count(c1));

  hazard_stall_controller #(.MD_LAT(1), .DELAY_SLOT(0), .CNT_W(16)) dut_l1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .branch_taken(branch_taken),
    .jump(jump), .md_start(md_start), .clr_stats(clr_stats),
    .pc_hold(o2[6]), .ifid_hold(o2[5]), .ifid_flush(o2[4]), .idex_hold(o2[3]),
    .idex_flush(o2[2]), .exmem_flush(o2[1]), .md_busy(o2[0]), .stall_count(c2));

  hazard_stall_controller #(.MD_LAT(2), .DELAY_SLOT(0), .CNT_W(16)) dut_l2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .branch_taken(branch_taken),
    .jump(jump), .md_start(md_start), .clr_stats(clr_stats),
    .pc_hold(o3[6]), .ifid_hold(o3[5]), .ifid_flush(o3[4]), .idex_hold(o3[3]),
    .idex_flush(o3[2]), .exmem_flush(o3[1]), .md_busy(o3[0]), .stall_count(c3));

  typedef struct packed {
    logic [3:0][6:0]  o;
    logic [3:0][15:0] c;
  } exp_t;

  exp_t sb[$];
  int   md_left[4];
  int   cnt_m[4];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [4:0] rd);
    return (rd != 5'd0) && (rd == id_rs || (id_uses_rt && rd == id_rt));
  endfunction

  // Reference behaviour for one variant given its remaining MD cycles
  function automatic logic [6:0] model_out(input int lat, input int ds, input int left);
    logic lu, br;
    lu = ex_mem_read && hit(ex_rd);
    br = id_is_branch && ((ex_reg_write && !ex_mem_read && hit(ex_rd)) ||
                          (mem_mem_read && hit(mem_rd)));
    if (reset) return 7'b0000000;
    if (left > 0 || (md_start && lat > 1)) return 7'b1101011;
    if (lu || br) return 7'b1100100;
    if ((branch_taken || jump) && ds == 0) return 7'b0010000;
    return 7'b0000000;
  endfunction

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    id_uses_rt = 1'b0; id_is_branch = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    mem_mem_read = 1'b0; branch_taken = 1'b0; jump = 1'b0; md_start = 1'b0;
    clr_stats = 1'b0; reset = 1'b0;
  endtask

  // Push expectation for the driven inputs, compare mid-cycle, advance model at the edge
  task automatic run_cycle();
    exp_t e, g;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        md_left[i] = 0;
        cnt_m[i]   = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      e.o[i] = model_out(LAT[i], DS[i], md_left[i]);
      e.c[i] = cnt_m[i][15:0];
    end
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("outs_dut%0d", i), {25'd0, act_o[i]}, {25'd0, g.o[i]});
      check_eq($sformatf("stall_count_dut%0d", i), {16'd0, act_c[i]}, {16'd0, g.c[i]});
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (reset) cnt_m[i] = 0;
      else if (clr_stats) cnt_m[i] = 0;
      else if (g.o[i][6] && cnt_m[i] < SAT[i]) cnt_m[i] = cnt_m[i] + 1;
      if (reset) md_left[i] = 0;
      else if (md_left[i] > 0) md_left[i] = md_left[i] - 1;
      else if (md_start && LAT[i] > 2) md_left[i] = LAT[i] - 2;
      else md_left[i] = 0;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      md_left[i] = 0;
      cnt_m[i]   = 0;
    end
    clear_in();
    reset = 1'b1;
    #1;
    run_cycle();
    check_eq("reset_outs", {25'd0, o0}, 32'd0);
    clear_in(); run_cycle();

    // load-use, then no match through r0, then rt with and without uses_rt
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; run_cycle();
    clear_in(); run_cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; run_cycle();
    clear_in(); ex_mem_read = 1'b1; ex_rd = 5'd12; id_rt = 5'd12; run_cycle();
    id_uses_rt = 1'b1; run_cycle();
    clear_in(); run_cycle();

    // branch after load: EX then MEM stall, then taken branch squashes the slot
    id_is_branch = 1'b1; id_rs = 5'd9; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
    run_cycle();
    check_eq("br_load_cyc1", {31'd0, o0[6]}, 32'd1);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0; mem_mem_read = 1'b1; mem_rd = 5'd9;
    branch_taken = 1'b1; run_cycle();
    check_eq("br_load_cyc2_noflush", {31'd0, o0[4]}, 32'd0);
    mem_mem_read = 1'b0; mem_rd = 5'd0; run_cycle();
    check_eq("br_taken_flush", {31'd0, o0[4]}, 32'd1);
    check_eq("br_taken_ds_noflush", {31'd0, o1[4]}, 32'd0);
    clear_in(); run_cycle();
    id_is_branch = 1'b1; id_rs = 5'd3; ex_reg_write = 1'b1; ex_rd = 5'd3; run_cycle();
    clear_in(); jump = 1'b1; run_cycle();
    clear_in(); run_cycle();

    // MULT with concurrent load-use; md_start held into the busy window
    md_start = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; run_cycle();
    run_cycle(); run_cycle();
    check_eq("md_busy_T2", {31'd0, o0[0]}, 32'd1);
    md_start = 1'b0; ex_mem_read = 1'b0; run_cycle();
    check_eq("md_done_T3", {31'd0, o0[0]}, 32'd0);
    clear_in(); run_cycle();

    // reset during the MD stall, then a fresh full stall
    md_start = 1'b1; run_cycle();
    md_start = 1'b0; reset = 1'b1; run_cycle();
    reset = 1'b0; run_cycle();
    md_start = 1'b1; run_cycle();
    md_start = 1'b0; run_cycle(); run_cycle(); run_cycle(); run_cycle();

    // counter saturation and clear-over-increment
    clr_stats = 1'b1; run_cycle();
    clear_in(); ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    for (int k = 0; k < 20; k++) run_cycle();
    check_eq("count_saturated", {28'd0, c0}, 32'd15);
    clr_stats = 1'b1; run_cycle();
    check_eq("count_cleared", {28'd0, c0}, 32'd0);
    clear_in(); run_cycle();

    // random traffic on a small register range to provoke matches
    for (int k = 0; k < 300; k++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1)); id_is_branch = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1)); ex_reg_write = 1'($urandom_range(0, 1));
      mem_mem_read = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 3) == 0); md_start = 1'($urandom_range(0, 7) == 0);
      clr_stats = 1'($urandom_range(0, 31) == 0); reset = 1'($urandom_range(0, 49) == 0);
      run_cycle();
    end
    clear_in(); run_cycle();

    check_eq("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
